// File: rtl/tl_track_pkg.sv
// tl_track_pkg: shared TileLink opcodes and burst-length helper for the in-flight tracker
package tl_track_pkg;

    localparam logic [2:0] OP_PUT_FULL        = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

    // Beats in a message minus one; only data-carrying messages wider than the bus span several beats.
    function automatic logic [31:0] beats_minus1(input logic [31:0] size, input logic has_data,
                                                 input int unsigned bus_log2 = 3);
        return (has_data && size > bus_log2) ? (32'd1 << (size - bus_log2)) - 32'd1 : 32'd0;
    endfunction

endpackage

// File: rtl/tl_beat_counter.sv
// tl_beat_counter: tracks position within a multi-beat TileLink message and flags first/last beats
module tl_beat_counter
    import tl_track_pkg::*;
#(
    parameter int SIZE_BITS      = 4,
    parameter int BUS_BYTES_LOG2 = 3,
    parameter int BEAT_BITS      = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 fire_i,
    input  logic [SIZE_BITS-1:0] size_i,
    input  logic                 has_data_i,
    output logic                 first_o,
    output logic                 last_o
);

    logic [BEAT_BITS-1:0] cnt_q, cnt_d, load;

    assign load = BEAT_BITS'(beats_minus1(32'(size_i), has_data_i, BUS_BYTES_LOG2));

    // Zero means the next beat opens a message; otherwise it holds the beats still to come.
    always_comb begin
        first_o = cnt_q == '0;
        last_o  = first_o ? load == '0 : cnt_q == BEAT_BITS'(1);
        cnt_d   = !fire_i ? cnt_q : first_o ? load : cnt_q - BEAT_BITS'(1);
    end

    // Beat counter register.
    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/tl_inflight_tracker.sv
// tl_inflight_tracker: per-source TileLink in-flight table producing registered size checks and protocol error pulses
module tl_inflight_tracker
    import tl_track_pkg::*;
#(
    parameter int SOURCE_BITS    = 4,
    parameter int SIZE_BITS      = 4,
    parameter int BUS_BYTES_LOG2 = 3,
    parameter int BEAT_BITS      = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   a_valid,
    input  logic                   a_ready,
    input  logic [2:0]             a_opcode,
    input  logic [SIZE_BITS-1:0]   a_size,
    input  logic [SOURCE_BITS-1:0] a_source,
    input  logic                   d_valid,
    input  logic                   d_ready,
    input  logic [2:0]             d_opcode,
    input  logic [SIZE_BITS-1:0]   d_size,
    input  logic [SOURCE_BITS-1:0] d_source,
    output logic                   chk_skip,
    output logic [SIZE_BITS-1:0]   chk_expected,
    output logic [SIZE_BITS-1:0]   chk_actual,
    output logic                   err_dup_source,
    output logic                   err_unexpected_d,
    output logic [SOURCE_BITS:0]   inflight_count
);

    localparam int DEPTH = 1 << SOURCE_BITS;

    logic                   a_fire, d_fire, a_has_data, d_has_data;
    logic                   a_first, a_last_unused, d_first, d_last;
    logic                   a_alloc, d_release, d_check, d_unexp, a_dup;
    logic [DEPTH-1:0]       inflight_q, inflight_d;
    logic [SIZE_BITS-1:0]   size_q [DEPTH];
    logic [SOURCE_BITS:0]   count_q, count_d;
    logic                   skip_q, dup_q, unexp_q;
    logic [SIZE_BITS-1:0]   exp_q, exp_d, act_q, act_d;

    assign a_fire     = a_valid && a_ready;
    assign d_fire     = d_valid && d_ready;
    assign a_has_data = a_opcode == OP_PUT_FULL || a_opcode == OP_PUT_PARTIAL;
    assign d_has_data = d_opcode == OP_ACCESS_ACK_DATA;

    tl_beat_counter #(
        .SIZE_BITS(SIZE_BITS), .BUS_BYTES_LOG2(BUS_BYTES_LOG2), .BEAT_BITS(BEAT_BITS)
    ) u_a_beats (
        .clock(clock), .reset(reset), .fire_i(a_fire), .size_i(a_size),
        .has_data_i(a_has_data), .first_o(a_first), .last_o(a_last_unused)
    );

    tl_beat_counter #(
        .SIZE_BITS(SIZE_BITS), .BUS_BYTES_LOG2(BUS_BYTES_LOG2), .BEAT_BITS(BEAT_BITS)
    ) u_d_beats (
        .clock(clock), .reset(reset), .fire_i(d_fire), .size_i(d_size),
        .has_data_i(d_has_data), .first_o(d_first), .last_o(d_last)
    );

    // Table decisions: a release on the same source frees the slot before the A side looks at it.
    always_comb begin
        d_release  = d_fire && d_last && inflight_q[d_source];
        a_alloc    = a_fire && a_first &&
                     (!inflight_q[a_source] || (d_release && d_source == a_source));
        a_dup      = a_fire && a_first && !a_alloc;
        d_check    = d_fire && d_first && inflight_q[d_source];
        d_unexp    = d_fire && d_first && !inflight_q[d_source];
        inflight_d = inflight_q;
        if (d_release) inflight_d[d_source] = 1'b0;
        if (a_alloc) inflight_d[a_source] = 1'b1;
        count_d    = (a_alloc && !d_release) ? count_q + (SOURCE_BITS+1)'(1) :
                     (d_release && !a_alloc) ? count_q - (SOURCE_BITS+1)'(1) : count_q;
        exp_d      = d_check ? size_q[d_source] : '0;
        act_d      = d_check ? d_size : '0;
    end

    // In-flight vector, counter and registered check/error outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            inflight_q <= '0;
            count_q    <= '0;
            skip_q     <= 1'b1;
            exp_q      <= '0;
            act_q      <= '0;
            dup_q      <= 1'b0;
            unexp_q    <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            count_q    <= count_d;
            skip_q     <= !d_check;
            exp_q      <= exp_d;
            act_q      <= act_d;
            dup_q      <= a_dup;
            unexp_q    <= d_unexp;
        end
    end

    // Size table is only meaningful where inflight is set, so it needs no reset.
    always_ff @(posedge clock) begin
        if (a_alloc) size_q[a_source] <= a_size;
    end

    assign chk_skip         = skip_q;
    assign chk_expected     = exp_q;
    assign chk_actual       = act_q;
    assign err_dup_source   = dup_q;
    assign err_unexpected_d = unexp_q;
    assign inflight_count   = count_q;

endmodule

// File: tb/tb_tl_inflight_tracker.sv
// tb_tl_inflight_tracker: directed scenarios plus randomized traffic against a transaction-level model
module tb_tl_inflight_tracker;

    localparam int SB = 4, ZB = 4, BL = 3;

    logic          clock = 1'b0, reset = 1'b0;
    logic          a_valid = 1'b0, a_ready = 1'b1, d_valid = 1'b0, d_ready = 1'b1;
    logic [2:0]    a_opcode = 3'd4, d_opcode = 3'd0;
    logic [ZB-1:0] a_size = '0, d_size = '0;
    logic [SB-1:0] a_source = '0, d_source = '0;
    logic          chk_skip, err_dup_source, err_unexpected_d;
    logic [ZB-1:0] chk_expected, chk_actual;
    logic [SB:0]   inflight_count;

    int n_checks = 0, n_fail = 0;

    bit m_inf [16];
    int m_size [16];
    int a_rem = 0, d_rem = 0;
    bit e_skip = 1, e_dup = 0, e_unexp = 0;
    int e_exp = 0, e_act = 0, e_cnt = 0;

    tl_inflight_tracker dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size), .a_source(a_source),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size), .d_source(d_source),
        .chk_skip(chk_skip), .chk_expected(chk_expected), .chk_actual(chk_actual),
        .err_dup_source(err_dup_source), .err_unexpected_d(err_unexpected_d),
        .inflight_count(inflight_count)
    );

    always #5 clock = ~clock;

    function automatic int nbeats(int size, bit has_data);
        return (has_data && size > BL) ? (1 << (size - BL)) : 1;
    endfunction

    // Transaction-level model: apply the current cycle's handshakes to the expected table.
    task automatic model_step();
        bit a_f, d_f, a_hd, d_hd, a_first, d_first, d_last, rel;
        int n;
        e_skip = 1; e_exp = 0; e_act = 0; e_dup = 0; e_unexp = 0;
        if (reset) begin
            foreach (m_inf[i]) m_inf[i] = 0;
            a_rem = 0; d_rem = 0; e_cnt = 0;
            return;
        end
        a_f = a_valid && a_ready;
        d_f = d_valid && d_ready;
        a_hd = a_opcode == 3'd0 || a_opcode == 3'd1;
        d_hd = d_opcode == 3'd1;
        a_first = a_rem == 0;
        d_first = d_rem == 0;
        d_last = d_first ? nbeats(int'(d_size), d_hd) == 1 : d_rem == 1;
        rel = d_f && d_last && m_inf[d_source];
        if (d_f && d_first) begin
            if (m_inf[d_source]) begin
                e_skip = 0; e_exp = m_size[d_source]; e_act = int'(d_size);
            end else e_unexp = 1;
        end
        if (rel) m_inf[d_source] = 0;
        if (a_f && a_first) begin
            if (m_inf[a_source]) e_dup = 1;
            else begin
                m_inf[a_source] = 1; m_size[a_source] = int'(a_size);
            end
        end
        if (a_f) a_rem = a_first ? nbeats(int'(a_size), a_hd) - 1 : a_rem - 1;
        if (d_f) d_rem = d_first ? nbeats(int'(d_size), d_hd) - 1 : d_rem - 1;
        n = 0;
        foreach (m_inf[i]) n += int'(m_inf[i]);
        e_cnt = n;
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_a(bit v, int op, int sz, int src);
        a_valid = v; a_opcode = 3'(op); a_size = ZB'(sz); a_source = SB'(src);
    endtask

    task automatic set_d(bit v, int op, int sz, int src);
        d_valid = v; d_opcode = 3'(op); d_size = ZB'(sz); d_source = SB'(src);
    endtask

    task automatic test_reset();
        set_a(0, 4, 0, 0); set_d(0, 0, 0, 0);
        reset = 1; tick(); tick(); reset = 0;
        n_checks++; if (chk_skip !== 1'b1) begin n_fail++; $display("FAIL reset_skip: got %0d want 1", chk_skip); end
        n_checks++; if (chk_expected !== 4'd0) begin n_fail++; $display("FAIL reset_expected: got %0d want 0", chk_expected); end
        n_checks++; if (chk_actual !== 4'd0) begin n_fail++; $display("FAIL reset_actual: got %0d want 0", chk_actual); end
        n_checks++; if (err_dup_source !== 1'b0 || err_unexpected_d !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0d/%0d want 0/0", err_dup_source, err_unexpected_d); end
        n_checks++; if (inflight_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", inflight_count); end
    endtask

    task automatic test_get_ack();
        set_a(1, 4, 2, 3); tick(); set_a(0, 4, 0, 0);
        n_checks++; if (inflight_count !== 5'd1) begin n_fail++; $display("FAIL get_count: got %0d want 1", inflight_count); end
        n_checks++; if (chk_skip !== 1'b1) begin n_fail++; $display("FAIL get_skip: got %0d want 1", chk_skip); end
        set_d(1, 1, 2, 3); tick(); set_d(0, 0, 0, 0);
        n_checks++; if ({chk_skip, chk_expected, chk_actual} !== {1'b0, 4'd2, 4'd2}) begin n_fail++; $display("FAIL get_ack_check: got skip=%0d exp=%0d act=%0d want 0/2/2", chk_skip, chk_expected, chk_actual); end
        n_checks++; if (inflight_count !== 5'd0) begin n_fail++; $display("FAIL get_ack_count: got %0d want 0", inflight_count); end
        tick();
        n_checks++; if (chk_skip !== 1'b1) begin n_fail++; $display("FAIL get_ack_skip_back: got %0d want 1", chk_skip); end
    endtask

    task automatic test_put_burst();
        set_a(1, 0, 6, 5); tick();
        n_checks++; if (inflight_count !== 5'd1) begin n_fail++; $display("FAIL put_count1: got %0d want 1", inflight_count); end
        for (int i = 1; i < 8; i++) begin
            set_a(1, 0, 1, 9); tick();
            n_checks++; if (err_dup_source !== 1'b0 || inflight_count !== 5'd1) begin n_fail++; $display("FAIL put_beat%0d: got dup=%0d cnt=%0d want 0/1", i + 1, err_dup_source, inflight_count); end
        end
        set_a(0, 4, 0, 0); set_d(1, 0, 5, 5); tick(); set_d(0, 0, 0, 0);
        n_checks++; if ({chk_skip, chk_expected, chk_actual} !== {1'b0, 4'd6, 4'd5}) begin n_fail++; $display("FAIL put_ack_check: got skip=%0d exp=%0d act=%0d want 0/6/5", chk_skip, chk_expected, chk_actual); end
        n_checks++; if (inflight_count !== 5'd0) begin n_fail++; $display("FAIL put_ack_count: got %0d want 0", inflight_count); end
        tick();
        n_checks++; if (chk_skip !== 1'b1) begin n_fail++; $display("FAIL put_skip_one_cycle: got %0d want 1", chk_skip); end
    endtask

    task automatic test_dup();
        set_a(1, 4, 2, 7); tick();
        set_a(1, 4, 4, 7); tick(); set_a(0, 4, 0, 0);
        n_checks++; if (err_dup_source !== 1'b1 || inflight_count !== 5'd1) begin n_fail++; $display("FAIL dup_pulse: got dup=%0d cnt=%0d want 1/1", err_dup_source, inflight_count); end
        tick();
        n_checks++; if (err_dup_source !== 1'b0) begin n_fail++; $display("FAIL dup_once: got %0d want 0", err_dup_source); end
        set_d(1, 0, 2, 7); tick(); set_d(0, 0, 0, 0);
        n_checks++; if ({chk_skip, chk_expected} !== {1'b0, 4'd2}) begin n_fail++; $display("FAIL dup_keeps_size: got skip=%0d exp=%0d want 0/2", chk_skip, chk_expected); end
    endtask

    task automatic test_unexpected();
        set_d(1, 0, 3, 2); tick(); set_d(0, 0, 0, 0);
        n_checks++; if ({err_unexpected_d, chk_skip} !== 2'b11) begin n_fail++; $display("FAIL unexp_pulse: got unexp=%0d skip=%0d want 1/1", err_unexpected_d, chk_skip); end
        n_checks++; if (inflight_count !== 5'd0) begin n_fail++; $display("FAIL unexp_count: got %0d want 0", inflight_count); end
        tick();
        n_checks++; if (err_unexpected_d !== 1'b0) begin n_fail++; $display("FAIL unexp_once: got %0d want 0", err_unexpected_d); end
    endtask

    task automatic test_same_cycle();
        set_a(1, 4, 1, 4); tick();
        set_a(1, 4, 3, 4); set_d(1, 0, 1, 4); tick(); set_a(0, 4, 0, 0); set_d(0, 0, 0, 0);
        n_checks++; if ({err_dup_source, err_unexpected_d} !== 2'b00) begin n_fail++; $display("FAIL same_cycle_err: got %0d/%0d want 0/0", err_dup_source, err_unexpected_d); end
        n_checks++; if (inflight_count !== 5'd1) begin n_fail++; $display("FAIL same_cycle_count: got %0d want 1", inflight_count); end
        tick();
        set_d(1, 1, 3, 4); tick(); set_d(0, 0, 0, 0);
        n_checks++; if ({chk_skip, chk_expected, chk_actual} !== {1'b0, 4'd3, 4'd3}) begin n_fail++; $display("FAIL same_cycle_realloc: got skip=%0d exp=%0d act=%0d want 0/3/3", chk_skip, chk_expected, chk_actual); end
    endtask

    task automatic test_reset_mid_burst();
        set_a(1, 4, 6, 6); tick(); set_a(0, 4, 0, 0);
        set_d(1, 1, 6, 6); tick();
        n_checks++; if (chk_skip !== 1'b0) begin n_fail++; $display("FAIL burst_first_check: got %0d want 0", chk_skip); end
        tick();
        reset = 1; tick(); reset = 0;
        n_checks++; if ({chk_skip, chk_expected, chk_actual, err_dup_source, err_unexpected_d, inflight_count} !== {1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 5'd0}) begin n_fail++; $display("FAIL mid_burst_reset: got skip=%0d exp=%0d act=%0d dup=%0d unexp=%0d cnt=%0d want 1/0/0/0/0/0", chk_skip, chk_expected, chk_actual, err_dup_source, err_unexpected_d, inflight_count); end
        tick(); set_d(0, 0, 0, 0);
        n_checks++; if ({err_unexpected_d, chk_skip} !== 2'b11) begin n_fail++; $display("FAIL post_reset_first_beat: got unexp=%0d skip=%0d want 1/1", err_unexpected_d, chk_skip); end
        tick();
    endtask

    task automatic test_random();
        reset = 1; tick(); reset = 0;
        for (int c = 0; c < 3000; c++) begin
            reset    = $urandom_range(0, 199) == 0;
            a_valid  = $urandom_range(0, 2) != 0;
            a_ready  = $urandom_range(0, 3) != 0;
            a_opcode = 3'($urandom_range(0, 5));
            a_size   = ZB'($urandom_range(0, 5));
            a_source = SB'($urandom_range(0, 3));
            d_valid  = $urandom_range(0, 2) != 0;
            d_ready  = $urandom_range(0, 3) != 0;
            d_opcode = 3'($urandom_range(0, 2));
            d_size   = ZB'($urandom_range(0, 5));
            d_source = SB'($urandom_range(0, 3));
            tick();
            n_checks++; if (chk_skip !== e_skip || chk_expected !== ZB'(e_exp) || chk_actual !== ZB'(e_act)) begin n_fail++; $display("FAIL rand_chk c=%0d: got %0d/%0d/%0d want %0d/%0d/%0d", c, chk_skip, chk_expected, chk_actual, e_skip, e_exp, e_act); end
            n_checks++; if (err_dup_source !== e_dup || err_unexpected_d !== e_unexp) begin n_fail++; $display("FAIL rand_err c=%0d: got %0d/%0d want %0d/%0d", c, err_dup_source, err_unexpected_d, e_dup, e_unexp); end
            n_checks++; if (inflight_count !== (SB+1)'(e_cnt)) begin n_fail++; $display("FAIL rand_count c=%0d: got %0d want %0d", c, inflight_count, e_cnt); end
        end
        reset = 0; a_ready = 1; d_ready = 1; set_a(0, 4, 0, 0); set_d(0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_get_ack();
        test_put_burst();
        test_dup();
        test_unexpected();
        test_same_cycle();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
